// File: rtl/core_pkg.sv
// Shared core definitions: ALU control codes, FU FSM states and
// default datapath widths used by decode, reservation station and FUs.
package core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSB = 4'd11,
    ALU_LW    = 4'd12,
    ALU_SW    = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    FU_IDLE   = 2'd0,
    FU_MEM    = 2'd1,
    FU_RESULT = 2'd2
  } fu_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU.
// Ports: a, b operands; alu_type ALUControl code; result (0 for unused codes).
module alu_core
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_type,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    case (alu_type)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = DATA_W'($signed(a) >>> shamt);
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, lt_u};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/fu_exec_unit.sv
// Single-issue execution unit: ALU ops (1-cycle) and word load/store via a
// req/ack memory port, with a held result broadcast until wb_ack.
// Ports: clk/reset_n; issue_* from RS; fu_ready; mem_* memory port;
// wb_* result bus with wb_ack grant.
module fu_exec_unit
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic              issue_is_LS,
  input  logic              issue_alusrc,
  input  logic [3:0]        issue_alu_type,
  input  logic [TAG_W-1:0]  issue_rd_tag,
  input  logic [TAG_W-1:0]  issue_rob_num,
  input  logic [DATA_W-1:0] issue_rs1_val,
  input  logic [DATA_W-1:0] issue_rs2_val,
  input  logic [DATA_W-1:0] issue_imm,
  output logic              fu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_val,
  output logic [TAG_W-1:0]  wb_rob_num,
  input  logic              wb_ack
);

  fu_state_e         state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              wb_valid_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_val_q;
  logic [TAG_W-1:0]  wb_rob_q;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              is_store;

  assign op_b     = issue_alusrc ? issue_imm : issue_rs2_val;
  assign is_store = issue_alu_type == ALU_SW;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a        (issue_rs1_val),
    .b        (op_b),
    .alu_type (issue_alu_type),
    .result   (alu_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_val_q    <= '0;
      wb_rob_q    <= '0;
    end else begin
      unique case (state_q)
        FU_IDLE: begin
          if (issue_valid) begin
            wb_tag_q <= issue_rd_tag;
            wb_rob_q <= issue_rob_num;
            if (issue_is_LS) begin
              state_q     <= FU_MEM;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= issue_rs1_val + issue_imm;
              mem_wdata_q <= is_store ? issue_rs2_val : '0;
            end else begin
              state_q    <= FU_RESULT;
              wb_valid_q <= 1'b1;
              wb_val_q   <= alu_res;
            end
          end
        end
        FU_MEM: begin
          if (mem_ack) begin
            state_q    <= FU_RESULT;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            // stores broadcast zero so the ROB sees a completed entry
            wb_val_q   <= mem_we_q ? '0 : mem_rdata;
          end
        end
        FU_RESULT: begin
          if (wb_ack) begin
            state_q    <= FU_IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= FU_IDLE;
      endcase
    end
  end

  // an issue while busy is dropped; flag it so RS bugs surface in sim
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(issue_valid && state_q != FU_IDLE))
        else $warning("fu_exec_unit: issue while busy dropped");
    end
  end

  assign fu_ready   = state_q == FU_IDLE;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_tag     = wb_tag_q;
  assign wb_val     = wb_val_q;
  assign wb_rob_num = wb_rob_q;

endmodule

// File: doc/fu_exec_unit.md
FU_EXEC_UNIT -- requirements
Module: fu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 6, physical-register tag and ROB-number width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid  input  1  issue from reservation station this cycle.
REQ-006 SHALL have ports issue_is_LS, issue_alusrc  input  1 each  load/store flag; select imm as operand B.
REQ-007 SHALL have port issue_alu_type  input  4  ALUControl code.
REQ-008 SHALL have ports issue_rd_tag, issue_rob_num  input  TAG_W each  destination tag; ROB entry.
REQ-009 SHALL have ports issue_rs1_val, issue_rs2_val, issue_imm  input  DATA_W each  operands.
REQ-010 SHALL have port fu_ready  output  1  unit can accept an issue next edge.
REQ-011 SHALL have ports mem_req, mem_we  output  1 each  memory request; write enable.
REQ-012 SHALL have ports mem_addr, mem_wdata  output  DATA_W each  address; store data.
REQ-013 SHALL have ports mem_ack  input  1, mem_rdata  input  DATA_W  memory completion; load data.
REQ-014 SHALL have ports wb_valid  output  1, wb_tag  output  TAG_W, wb_val  output  DATA_W, wb_rob_num  output  TAG_W  result broadcast (feeds RS wakeup and ROB).
REQ-015 SHALL have port wb_ack  input  1  writeback bus grant.

Function
REQ-016 SHALL implement FSM states IDLE, MEM, RESULT; fu_ready = (state==IDLE).
REQ-017 IDLE with issue_valid SHALL latch all issue fields; non-LS -> RESULT next edge, LS -> MEM next edge.
REQ-018 issue_valid while not IDLE SHALL be ignored with no state change (simulation assertion fires).
REQ-019 Operand B SHALL be issue_imm when alusrc=1, else issue_rs2_val.
REQ-020 ALU codes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 pass-B (LUI); 0 and 14-15 yield result 0 but still write back.
REQ-021 Shifts SHALL use B[4:0]; add/sub SHALL wrap modulo 2^DATA_W, no overflow flag.
REQ-022 ALU result SHALL be registered; wb_valid asserts the cycle after issue (1-cycle latency).
REQ-023 LS: code 12 = load word, 13 = store word; mem_addr = rs1 + imm; mem_we=1 and mem_wdata=rs2 for store.
REQ-024 In MEM, mem_req and all mem_* outputs SHALL stay high/stable until mem_ack sampled high.
REQ-025 On mem_ack: load latches mem_rdata as wb_val; store sets wb_val=0; -> RESULT next edge; mem_req drops the same edge.
REQ-026 mem_ack outside MEM SHALL be ignored.
REQ-027 In RESULT, wb_valid=1 with wb_tag/wb_val/wb_rob_num stable until wb_ack; on wb_ack -> IDLE, fu_ready high next cycle.
REQ-028 Issue SHALL NOT be accepted in the same cycle as wb_ack (no bypass from RESULT to busy).
REQ-029 wb_ack outside RESULT SHALL be ignored.

Reset
REQ-030 reset_n low SHALL force state IDLE immediately, including mid-MEM or mid-RESULT, dropping in-flight op.
REQ-031 Reset values: fu_ready=1; mem_req=0; mem_we=0; wb_valid=0; mem_addr, mem_wdata, wb_tag, wb_val, wb_rob_num = 0.

Structure
REQ-032 ALUControl code constants, FSM state encoding, DATA_W/TAG_W defaults SHALL live in shared package core_pkg, also used by reservation station and decode.
REQ-033 Combinational ALU SHALL be sub-module alu_core (inputs a, b, alu_type; output result).

Verification
REQ-034 ADD: rs1=5, imm=7, alusrc=1, rd_tag=12, rob=3 -> next cycle wb_valid=1, wb_val=12, wb_tag=12, wb_rob_num=3.
REQ-035 SRA: rs1=0x80000000, rs2=0x24 (shift 4), alusrc=0 -> wb_val=0xF8000000; SLT -1<1 -> 1, SLTU -> 0.
REQ-036 Load: rs1=0x100, imm=4 -> mem_req with mem_addr=0x104, mem_we=0; mem_ack after 3 cycles with rdata=0xDEADBEEF -> wb_val=0xDEADBEEF; fu_ready low throughout.
REQ-037 Backpressure: wb_ack held low 5 cycles -> wb_* stable, second issue_valid ignored; wb_ack -> fu_ready=1 next cycle.
REQ-038 reset_n pulsed low during MEM -> mem_req=0, wb_valid=0, fu_ready=1 immediately; later mem_ack ignored.
